sync_fifo_param: RTL

//  Parametrised single-clock FIFO; successor to the fixed 8-bit FIFO behind fifo_intf.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/sync_fifo_param_if.sv | 36 +++
 rtl/fifo_mem.sv | 24 ++
 rtl/sync_fifo_param.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// Imported by the interface, memory and top.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic af;
    logic ae;
    logic ovf;
    logic udf;
  } fifo_status_t;

  function automatic int addr_w(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param.
// The FIFO sits on the slave side; the stage driving it holds the master side.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int AW = addr_w(DEPTH);

    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [AW:0]           count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, rd_en, data_in, err_clr,
        input  data_out, full, empty, almost_full,
        input  almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en, data_in, err_clr,
        output data_out, full, empty, almost_full,
        output almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Contents are deliberately left unreset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold
// flags, sticky error flags and optional first-word-fall-through.
module sync_fifo_param
  import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0
) (
    input logic               clk,
    input logic               rst,
    sync_fifo_param_if.slave  bus
);

    localparam int AW = addr_w(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL out of range");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AE_LEVEL out of range");
    end

    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    fifo_status_t          status_q, status_d;

    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_ptr_msb;

    assign rd_ok = bus.rd_en & ~status_q.empty;
    assign wr_ok = bus.wr_en & (~status_q.full | rd_ok);

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    // Pointer MSBs only give the natural 2*DEPTH wrap; occupancy comes from count.
    assign unused_ptr_msb = wr_ptr_q[AW] ^ rd_ptr_q[AW];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + CW'(1);
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
            dout_d   = rd_data;
        end
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Error set terms win over err_clr in the same cycle.
    always_comb begin
        status_d.full  = (count_d == CW'(DEPTH));
        status_d.empty = (count_d == '0);
        status_d.af    = (count_d >= CW'(AF_LEVEL));
        status_d.ae    = (count_d <= CW'(AE_LEVEL));
        status_d.ovf   = (bus.wr_en & status_q.full & ~rd_ok)
                       | (status_q.ovf & ~bus.err_clr);
        status_d.udf   = (bus.rd_en & status_q.empty)
                       | (status_q.udf & ~bus.err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            status_q <= '{full: 1'b0, empty: 1'b1, af: 1'b0,
                          ae: 1'b1, ovf: 1'b0, udf: 1'b0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            status_q <= status_d;
        end
    end

    // FWFT shows the head word while non-empty, else the last popped word.
    if (FWFT) begin : g_fwft
        assign bus.data_out = status_q.empty ? dout_q : rd_data;
    end else begin : g_std
        assign bus.data_out = dout_q;
    end

    assign bus.full         = status_q.full;
    assign bus.empty        = status_q.empty;
    assign bus.almost_full  = status_q.af;
    assign bus.almost_empty = status_q.ae;
    assign bus.count        = count_q;
    assign bus.overflow     = status_q.ovf;
    assign bus.underflow    = status_q.udf;

endmodule
